cover_toggle_collector: RTL and testbench
=========================================

// Module: cover_toggle_collector
// PURPOSE
//  Consumer side of the toggle-coverage hit interface: takes a per-group W-bit hit
//  vector (one bit per toggle point) and records first-time hits in a sticky bitmap.
//  Each newly covered point is reported once, in ascending index order, on a
//  valid/ready stream carrying its global cover index.
//  Sits between a toggle-point group and the coverage aggregator / formal-side sink.
// PARAMETERS
//  W            28   number of toggle points in the group (1..256)
//  COVER_INDEX  0    global index of bit 0 of the group
//  IDX_W        32   width of reported cover index
// PORTS
//  clock         in   1              sole clock, rising edge
//  reset_n       in   1              asynchronous active-low reset
//  en            in   1              sample enable; valid ignored when 0
//  clear         in   1              synchronous clear of coverage state
//  valid         in   W              hit vector, bit i = point COVER_INDEX+i hit this cycle
//  out_valid     out  1              report available
//  out_ready     in   1              sink accepts report
//  out_index     out  IDX_W          COVER_INDEX + bit position of reported point
//  covered_cnt   out  $clog2(W+1)    number of distinct points covered
//  all_covered   out  1              every bit of the sticky bitmap set
//  total_cnt     out  32             total hit events (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset_n=0): seen, pending, out_valid, out_index, covered_cnt,
//    all_covered, total_cnt all 0 immediately; held until reset_n=1.
//  - new = valid & ~seen & {W{en}}; at clock edge: seen |= new, pending |= new,
//    covered_cnt += popcount(new). Repeat hits on seen bits have no effect.
//  - Output register: load when !out_valid or (out_valid & out_ready). On load,
//    if pending!=0: select lowest set bit p, out_index <= COVER_INDEX+p
//    (zero-extended to IDX_W), out_valid <= 1, clear pending[p] same edge;
//    else out_valid <= 0.
//  - Latency: hit sampled at edge N -> pending at N -> out_valid high after edge N+1.
//  - Throughput: one report per cycle with out_ready held 1.
//  - Handshake: out_valid and out_index stable while out_valid & !out_ready;
//    out_valid never drops without acceptance except on reset.
//  - Order: strictly ascending by bit position among pending at each load;
//    a later lower-index hit can precede already-pending higher indices.
//  - Each point reported exactly once per clear epoch; pending bit can never be
//    re-set for a bit being loaded (seen already 1).
//  - clear=1: seen, pending, covered_cnt <= 0; valid that cycle ignored (clear
//    wins); in-flight out register not dropped, completes its handshake; no
//    new load from pending that cycle. total_cnt unaffected.
//  - all_covered = &seen (registered via seen, combinational from it).
//  - covered_cnt never exceeds W; no wrap.
// CONFIGURATION
//  COVER_TOGGLE_TOTAL_CNT_EN defined: total_cnt += popcount(valid) each cycle with
//    en=1 (repeats included), saturating at 32'hFFFF_FFFF; reset only by reset_n.
//  Not defined: no counter/popcount logic; total_cnt tied to 0.
// TESTING (W=28, COVER_INDEX=100)
//  1 reset, valid=28'h1 one cycle, out_ready=1 -> one beat out_index=100 two edges
//    later; covered_cnt=1; no further beats.
//  2 valid=28'h5 held 10 cycles -> exactly two beats 100 then 102; covered_cnt=2.
//  3 out_ready=0, valid=all ones one cycle -> out_valid=1, out_index=100 stable
//    20 cycles; then out_ready=1 -> 28 back-to-back beats 100..127; all_covered=1,
//    covered_cnt=28, then out_valid=0.
//  4 during test-3 drain after 5 accepted beats assert clear one cycle -> in-flight
//    beat (105) completes, no more beats; covered_cnt=0, all_covered=0; valid=28'h1
//    -> 100 reported again.
//  5 reset_n=0 asynchronously mid-drain -> out_valid, covered_cnt, all_covered
//    0 before next edge; after release no beats without new hits.
//  6 COVER_TOGGLE_TOTAL_CNT_EN: valid=28'h3 with en=1 for 4 cycles, en=0 for 2 ->
//    total_cnt=8; undefined -> total_cnt=0.

Source files
------------

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: sticky toggle-coverage bitmap reporting each first hit once, lowest index first.
// Optional COVER_TOGGLE_TOTAL_CNT_EN adds a saturating count of all hit events.
module cover_toggle_collector #(
    parameter int W           = 28,
    parameter int COVER_INDEX = 0,
    parameter int IDX_W       = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [W-1:0]             valid_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [IDX_W-1:0]         out_index_o,
    output logic [$clog2(W+1)-1:0]   covered_cnt_o,
    output logic                     all_covered_o,
    output logic [31:0]              total_cnt_o
);
    localparam int CW = $clog2(W+1);
    localparam int SW = W > 1 ? $clog2(W) : 1;

    logic [W-1:0]     seen_q, seen_d, pend_q, pend_d, new_hit;
    logic [CW-1:0]    cnt_q, cnt_d, pop;
    logic [SW-1:0]    sel;
    logic             out_valid_q, out_valid_d, load, take;
    logic [IDX_W-1:0] out_index_q, out_index_d;

    assign new_hit = valid_i & ~seen_q & {W{en_i}};
    assign load    = !out_valid_q || out_ready_i;
    assign take    = load && (|pend_q) && !clear_i;

    always_comb begin
        sel = '0;
        for (int i = W-1; i >= 0; i--) if (pend_q[i]) sel = SW'(i);
        pop = '0;
        for (int i = 0; i < W; i++) pop = pop + CW'(new_hit[i]);
    end

    // clear wins over same-cycle hits; the in-flight beat keeps its handshake
    assign seen_d      = clear_i ? '0 : seen_q | new_hit;
    assign pend_d      = clear_i ? '0 : (pend_q | new_hit) & ~(take ? W'(1) << sel : '0);
    assign cnt_d       = clear_i ? '0 : cnt_q + pop;
    assign out_valid_d = load ? take : out_valid_q;
    assign out_index_d = take ? IDX_W'(COVER_INDEX) + IDX_W'(sel) : out_index_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seen_q      <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
        end else begin
            seen_q      <= seen_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_index_o   = out_index_q;
    assign covered_cnt_o = cnt_q;
    assign all_covered_o = &seen_q;

`ifdef COVER_TOGGLE_TOTAL_CNT_EN
    logic [31:0] tot_q;
    logic [8:0]  tpop;
    logic [32:0] tsum;

    always_comb begin
        tpop = '0;
        for (int i = 0; i < W; i++) tpop = tpop + 9'(valid_i[i]);
    end

    assign tsum = {1'b0, tot_q} + 33'(tpop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tot_q <= '0;
        else if (en_i) tot_q <= tsum[32] ? '1 : tsum[31:0];
    end

    assign total_cnt_o = tot_q;
`else
    assign total_cnt_o = '0;
`endif
endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector: vector table, directed corner sequences and random run against a reference model.
module tb_cover_toggle_collector;
    localparam int W  = 28;
    localparam int CI = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, clr = 1'b0, rdy = 1'b0;
    logic [W-1:0]  vld = '0;
    logic          out_valid, all_cov;
    logic [31:0]   out_index, total_cnt;
    logic [4:0]    covered_cnt;

    int n_chk = 0, n_fail = 0;
    int beats[$];

    bit     m_seen[W], m_pend[W];
    bit     m_ov;
    int     m_oi, m_cnt;
    longint m_tot;

    typedef struct {
        bit          rst;
        bit          e;
        bit          c;
        logic [27:0] v;
        bit          r;
        bit          ov;
        int          oi;
        int          cnt;
    } vec_t;
    vec_t tbl[$];

    cover_toggle_collector #(.W(W), .COVER_INDEX(CI), .IDX_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr), .valid_i(vld),
        .out_valid_o(out_valid), .out_ready_i(rdy), .out_index_o(out_index),
        .covered_cnt_o(covered_cnt), .all_covered_o(all_cov), .total_cnt_o(total_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_seen[k]) begin m_seen[k] = 0; m_pend[k] = 0; end
        m_ov = 0; m_oi = 0; m_cnt = 0; m_tot = 0;
    endtask

    task automatic model_update(input bit e, input bit c, input logic [W-1:0] v, input bit r);
        bit load;
        int p;
        load = !m_ov || r;
        p = -1;
        for (int k = W-1; k >= 0; k--) if (m_pend[k]) p = k;
        if (load) begin
            if (!c && p >= 0) begin m_ov = 1; m_oi = CI + p; m_pend[p] = 0; end
            else m_ov = 0;
        end
        if (c) begin
            foreach (m_seen[k]) begin m_seen[k] = 0; m_pend[k] = 0; end
            m_cnt = 0;
        end else begin
            for (int k = 0; k < W; k++)
                if (e && v[k] && !m_seen[k]) begin m_seen[k] = 1; m_pend[k] = 1; m_cnt++; end
        end
        if (e) begin
            m_tot += $countones(v);
            if (m_tot > 64'hFFFF_FFFF) m_tot = 64'hFFFF_FFFF;
        end
    endtask

    task automatic cmp_model();
        bit all;
        all = 1;
        foreach (m_seen[k]) if (!m_seen[k]) all = 0;
        chk("rand out_valid", out_valid, m_ov);
        if (m_ov) chk("rand out_index", out_index, m_oi);
        chk("rand covered_cnt", covered_cnt, m_cnt);
        chk("rand all_covered", all_cov, all);
`ifdef COVER_TOGGLE_TOTAL_CNT_EN
        chk("rand total_cnt", total_cnt, m_tot);
`else
        chk("rand total_cnt", total_cnt, 0);
`endif
    endtask

    task automatic step(input bit e, input bit c, input logic [W-1:0] v, input bit r);
        en = e; clr = c; vld = v; rdy = r;
        #1;
        if (out_valid && r) beats.push_back(int'(out_index));
        model_update(e, c, v, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 0; clr = 0; vld = '0; rdy = 0;
        model_reset();
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset covered_cnt", covered_cnt, 0);
        chk("reset all_covered", all_cov, 0);
        chk("reset total_cnt", total_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        beats.delete();
    endtask

    initial begin
        @(negedge clk);
        // test 1 and test 2 as vectors: expected state after each edge
        tbl.push_back('{1, 1, 0, 28'h1, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 28'h0, 1, 1, 100, 1});
        tbl.push_back('{0, 1, 0, 28'h0, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 28'h0, 1, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 28'h5, 1, 0, 0, 2});
        tbl.push_back('{0, 1, 0, 28'h5, 1, 1, 100, 2});
        tbl.push_back('{0, 1, 0, 28'h5, 1, 1, 102, 2});
        for (int i = 0; i < 7; i++) tbl.push_back('{0, 1, 0, 28'h5, 1, 0, 0, 2});
        tbl.push_back('{0, 1, 0, 28'h0, 1, 0, 0, 2});
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].e, tbl[i].c, tbl[i].v, tbl[i].r);
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
            if (tbl[i].ov) chk($sformatf("vec%0d out_index", i), out_index, tbl[i].oi);
            chk($sformatf("vec%0d covered_cnt", i), covered_cnt, tbl[i].cnt);
        end

        // test 3: backpressure hold then full drain
        do_reset();
        step(1, 0, '1, 0);
        step(1, 0, '0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("hold out_valid", out_valid, 1);
            chk("hold out_index", out_index, 100);
            step(1, 0, '0, 0);
        end
        for (int i = 0; i < 30; i++) step(1, 0, '0, 1);
        chk("drain beats", beats.size(), 28);
        foreach (beats[k]) chk($sformatf("drain beat%0d", k), beats[k], 100 + k);
        chk("drain out_valid", out_valid, 0);
        chk("drain covered_cnt", covered_cnt, 28);
        chk("drain all_covered", all_cov, 1);

        // test 4: clear during drain
        do_reset();
        step(1, 0, '1, 0);
        step(1, 0, '0, 0);
        for (int i = 0; i < 20 && beats.size() < 5; i++) step(1, 0, '0, 1);
        chk("clr pre beats", beats.size(), 5);
        chk("clr inflight index", out_index, 105);
        step(1, 1, '0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, '0, 1);
        chk("clr beats", beats.size(), 6);
        chk("clr last beat", beats[beats.size()-1], 105);
        chk("clr out_valid", out_valid, 0);
        chk("clr covered_cnt", covered_cnt, 0);
        chk("clr all_covered", all_cov, 0);
        step(1, 0, 28'h1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, '0, 1);
        chk("reclr beats", beats.size(), 7);
        chk("reclr beat", beats[beats.size()-1], 100);
        chk("reclr covered_cnt", covered_cnt, 1);

        // test 5: asynchronous reset mid-drain
        do_reset();
        step(1, 0, '1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, '0, 1);
        chk("async pre out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", out_valid, 0);
        chk("async covered_cnt", covered_cnt, 0);
        chk("async all_covered", all_cov, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        beats.delete();
        for (int i = 0; i < 10; i++) step(1, 0, '0, 1);
        chk("async post beats", beats.size(), 0);
        chk("async post out_valid", out_valid, 0);

        // test 6: total hit events
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 28'h3, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 28'h3, 1);
`ifdef COVER_TOGGLE_TOTAL_CNT_EN
        chk("total_cnt", total_cnt, 8);
`else
        chk("total_cnt", total_cnt, 0);
`endif

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] v;
            v = W'($urandom & $urandom & $urandom & $urandom);
            step($urandom % 8 != 0, $urandom % 40 == 0, v, $urandom % 4 != 0);
            cmp_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
